// File: rtl/ex_alu_md_pkg.sv
// rtl/ex_alu_md_pkg.sv - operation codes, result classes and divider state encodings
package ex_alu_md_pkg;

    localparam int ALU_OP_W  = 8;
    localparam int ALU_SEL_W = 3;

    typedef logic [ALU_OP_W-1:0]  alu_op_t;
    typedef logic [ALU_SEL_W-1:0] alu_sel_t;

    localparam logic RST_ENABLE = 1'b1;

    localparam alu_sel_t SEL_NOP   = 3'b000;
    localparam alu_sel_t SEL_LOGIC = 3'b001;
    localparam alu_sel_t SEL_SHIFT = 3'b010;
    localparam alu_sel_t SEL_MOVE  = 3'b011;
    localparam alu_sel_t SEL_ARITH = 3'b100;

    localparam alu_op_t OP_NOP   = 8'b0000_0000;
    localparam alu_op_t OP_AND   = 8'b0010_0100;
    localparam alu_op_t OP_OR    = 8'b0010_0101;
    localparam alu_op_t OP_XOR   = 8'b0010_0110;
    localparam alu_op_t OP_NOR   = 8'b0010_0111;
    localparam alu_op_t OP_SLL   = 8'b0111_1100;
    localparam alu_op_t OP_SRL   = 8'b0000_0010;
    localparam alu_op_t OP_SRA   = 8'b0000_0011;
    localparam alu_op_t OP_ADD   = 8'b0010_0000;
    localparam alu_op_t OP_ADDU  = 8'b0010_0001;
    localparam alu_op_t OP_SUB   = 8'b0010_0010;
    localparam alu_op_t OP_SUBU  = 8'b0010_0011;
    localparam alu_op_t OP_SLT   = 8'b0010_1010;
    localparam alu_op_t OP_SLTU  = 8'b0010_1011;
    localparam alu_op_t OP_MFHI  = 8'b0001_0000;
    localparam alu_op_t OP_MTHI  = 8'b0001_0001;
    localparam alu_op_t OP_MFLO  = 8'b0001_0010;
    localparam alu_op_t OP_MTLO  = 8'b0001_0011;
    localparam alu_op_t OP_MULT  = 8'b0001_1000;
    localparam alu_op_t OP_MULTU = 8'b0001_1001;
    localparam alu_op_t OP_DIV   = 8'b0001_1010;
    localparam alu_op_t OP_DIVU  = 8'b0001_1011;

    localparam logic [1:0] DIV_FREE   = 2'b00;
    localparam logic [1:0] DIV_BYZERO = 2'b01;
    localparam logic [1:0] DIV_ON     = 2'b10;
    localparam logic [1:0] DIV_END    = 2'b11;

endpackage

// File: rtl/ex_alu_md_if.sv
// rtl/ex_alu_md_if.sv - ID/EX side inputs and EX/MEM side outputs of the execute stage
interface ex_alu_md_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    import ex_alu_md_pkg::*;

    alu_sel_t                alusel_i;
    alu_op_t                 aluop_i;
    logic [DATA_W-1:0]       reg1_data_i;
    logic [DATA_W-1:0]       reg2_data_i;
    logic [REG_ADDR_W-1:0]   waddr_i;
    logic                    reg_we_i;
    logic [DATA_W-1:0]       hi_i;
    logic [DATA_W-1:0]       lo_i;
    logic                    annul_i;

    logic [REG_ADDR_W-1:0]   waddr_o;
    logic                    reg_we_o;
    logic [DATA_W-1:0]       alu_res_o;
    logic                    whilo_o;
    logic [DATA_W-1:0]       hi_o;
    logic [DATA_W-1:0]       lo_o;
    logic                    stall_req_o;

    modport master (
        output alusel_i, aluop_i, reg1_data_i, reg2_data_i, waddr_i, reg_we_i, hi_i, lo_i, annul_i,
        input  waddr_o, reg_we_o, alu_res_o, whilo_o, hi_o, lo_o, stall_req_o
    );

    modport slave (
        input  alusel_i, aluop_i, reg1_data_i, reg2_data_i, waddr_i, reg_we_i, hi_i, lo_i, annul_i,
        output waddr_o, reg_we_o, alu_res_o, whilo_o, hi_o, lo_o, stall_req_o
    );
endinterface

// File: rtl/ex_div.sv
// rtl/ex_div.sv - restoring shift-subtract divider FSM, present only when EX_DIV_EN is defined
`ifdef EX_DIV_EN
module ex_div #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic              annul_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);
    import ex_alu_md_pkg::*;

    localparam int CNT_W = $clog2(DATA_W);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_divisor;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_sub;

    assign w_a_neg = signed_i & dividend_i[DATA_W-1];
    assign w_b_neg = signed_i & divisor_i[DATA_W-1];
    assign w_a_mag = w_a_neg ? -dividend_i : dividend_i;
    assign w_b_mag = w_b_neg ? -divisor_i : divisor_i;

    // Partial remainder stays below the divisor, so DATA_W+1 bits hold the shifted value and its borrow.
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_sub   = w_shift - {1'b0, r_divisor};

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state   <= DIV_FREE;
            r_cnt     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else if (annul_i) begin
            r_state <= DIV_FREE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    if (start_i) begin
                        r_cnt <= '0;
                        if (divisor_i == '0) begin
                            r_state <= DIV_BYZERO;
                            r_quo   <= '1;
                            r_rem   <= dividend_i;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            r_state   <= DIV_ON;
                            r_quo     <= w_a_mag;
                            r_rem     <= '0;
                            r_divisor <= w_b_mag;
                            r_neg_q   <= w_a_neg ^ w_b_neg;
                            r_neg_r   <= w_a_neg;
                        end
                    end
                end
                DIV_BYZERO: r_state <= DIV_END;
                DIV_ON: begin
                    if (w_sub[DATA_W]) begin
                        r_rem <= w_shift[DATA_W-1:0];
                        r_quo <= {r_quo[DATA_W-2:0], 1'b0};
                    end else begin
                        r_rem <= w_sub[DATA_W-1:0];
                        r_quo <= {r_quo[DATA_W-2:0], 1'b1};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(DATA_W - 1)) begin
                        r_state <= DIV_END;
                    end
                end
                default: r_state <= DIV_FREE;
            endcase
        end
    end

    assign ready_o     = (r_state == DIV_END);
    assign quotient_o  = r_neg_q ? -r_quo : r_quo;
    assign remainder_o = r_neg_r ? -r_rem : r_rem;

endmodule
`endif

// File: rtl/ex_alu_md.sv
// rtl/ex_alu_md.sv - execute stage: ALU, multiply, optional iterative divide (EX_DIV_EN)
module ex_alu_md #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic      clk,
    input  logic      rst,
    ex_alu_md_if.slave bus
);
    import ex_alu_md_pkg::*;

    localparam int SHW = $clog2(DATA_W);
    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [SHW-1:0]      w_shamt;
    logic [DATA_W-1:0]   w_sum;
    logic                w_ov;
    logic                w_slt;
    logic                w_sltu;
    logic                w_mul_signed;
    logic [2*DATA_W-1:0] w_ma;
    logic [2*DATA_W-1:0] w_mb;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_logic;
    logic [DATA_W-1:0]   w_shift;
    logic [DATA_W-1:0]   w_arith;
    logic [DATA_W-1:0]   w_move;
    logic [DATA_W-1:0]   w_res;
    logic                w_whilo;
    logic [DATA_W-1:0]   w_hi;
    logic [DATA_W-1:0]   w_lo;
    logic                w_stall;

    assign w_a     = bus.reg1_data_i;
    assign w_b     = bus.reg2_data_i;
    assign w_shamt = w_a[SHW-1:0];
    assign w_sum   = (bus.aluop_i == OP_SUB || bus.aluop_i == OP_SUBU) ? w_a - w_b : w_a + w_b;
    assign w_slt   = $signed(w_a) < $signed(w_b);
    assign w_sltu  = w_a < w_b;

    // Only the trapping forms kill the write; the wrapped sum is still driven out.
    assign w_ov = (bus.aluop_i == OP_ADD) ? ((w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB])) :
                  (bus.aluop_i == OP_SUB) ? ((w_a[MSB] != w_b[MSB]) && (w_sum[MSB] != w_a[MSB])) :
                  1'b0;

    assign w_mul_signed = (bus.aluop_i == OP_MULT);
    assign w_ma   = {{DATA_W{w_mul_signed & w_a[MSB]}}, w_a};
    assign w_mb   = {{DATA_W{w_mul_signed & w_b[MSB]}}, w_b};
    assign w_prod = w_ma * w_mb;

`ifdef EX_DIV_EN
    logic              w_div_op;
    logic              w_div_ready;
    logic [DATA_W-1:0] w_div_quo;
    logic [DATA_W-1:0] w_div_rem;

    assign w_div_op = (bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_DIVU);

    ex_div #(.DATA_W(DATA_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (w_div_op & ~bus.annul_i),
        .signed_i   (bus.aluop_i == OP_DIV),
        .annul_i    (bus.annul_i),
        .dividend_i (w_a),
        .divisor_i  (w_b),
        .ready_o    (w_div_ready),
        .quotient_o (w_div_quo),
        .remainder_o(w_div_rem)
    );

    assign w_stall = w_div_op & ~w_div_ready & ~bus.annul_i;
`else
    logic w_unused_clk;
    assign w_unused_clk = clk;
    assign w_stall      = 1'b0;
`endif

    always_comb begin
        w_logic = '0;
        w_shift = '0;
        w_arith = '0;
        w_move  = '0;
        case (bus.aluop_i)
            OP_OR:   w_logic = w_a | w_b;
            OP_AND:  w_logic = w_a & w_b;
            OP_XOR:  w_logic = w_a ^ w_b;
            OP_NOR:  w_logic = ~(w_a | w_b);
            OP_SLL:  w_shift = w_b << w_shamt;
            OP_SRL:  w_shift = w_b >> w_shamt;
            OP_SRA:  w_shift = $signed(w_b) >>> w_shamt;
            OP_ADD, OP_ADDU, OP_SUB, OP_SUBU: w_arith = w_sum;
            OP_SLT:  w_arith = {{(DATA_W-1){1'b0}}, w_slt};
            OP_SLTU: w_arith = {{(DATA_W-1){1'b0}}, w_sltu};
            OP_MFHI: w_move  = bus.hi_i;
            OP_MFLO: w_move  = bus.lo_i;
            default: w_logic = '0;
        endcase

        case (bus.alusel_i)
            SEL_LOGIC: w_res = w_logic;
            SEL_SHIFT: w_res = w_shift;
            SEL_ARITH: w_res = w_arith;
            SEL_MOVE:  w_res = w_move;
            default:   w_res = '0;
        endcase
    end

    always_comb begin
        w_whilo = 1'b0;
        w_hi    = '0;
        w_lo    = '0;
        case (bus.aluop_i)
            OP_MTHI: begin
                w_whilo = 1'b1;
                w_hi    = w_a;
                w_lo    = bus.lo_i;
            end
            OP_MTLO: begin
                w_whilo = 1'b1;
                w_hi    = bus.hi_i;
                w_lo    = w_a;
            end
            OP_MULT, OP_MULTU: begin
                w_whilo = 1'b1;
                {w_hi, w_lo} = w_prod;
            end
`ifdef EX_DIV_EN
            OP_DIV, OP_DIVU: begin
                w_whilo = w_div_ready & ~bus.annul_i;
                w_hi    = w_div_rem;
                w_lo    = w_div_quo;
            end
`endif
            default: w_whilo = 1'b0;
        endcase
    end

    assign bus.waddr_o     = rst ? '0 : bus.waddr_i;
    assign bus.reg_we_o    = ~rst & bus.reg_we_i & ~w_ov;
    assign bus.alu_res_o   = rst ? '0 : w_res;
    assign bus.whilo_o     = ~rst & w_whilo;
    assign bus.hi_o        = rst ? '0 : w_hi;
    assign bus.lo_o        = rst ? '0 : w_lo;
    assign bus.stall_req_o = ~rst & w_stall;

endmodule

// File: doc/ex_alu_md.md
# ex_alu_md

Parametrised execute stage for the in-order pipeline, placed between the ID/EX and EX/MEM registers. It performs:
- logic, shift and add/subtract/compare operations;
- single-cycle multiply into HI/LO;
- iterative multi-cycle divide into HI/LO, which stalls the pipeline through the control unit.

Results, write-back address and HI/LO write requests go to EX/MEM combinationally. Only the divider holds state.

## Interface
- DATA_W, 32: operand/result width; even, ≥8
- REG_ADDR_W, 5: register-file address width
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset (`RstEnable`)
- alusel_i  in  `AluSelBus`  result class: LOGIC, SHIFT, ARITH, MOVE, NOP
- aluop_i  in  `AluOpBus`  operation code
- reg1_data_i, reg2_data_i  in  DATA_W  source operands
- waddr_i  in  REG_ADDR_W  destination register
- reg_we_i  in  1  destination write enable
- hi_i, lo_i  in  DATA_W  current HI/LO, already forwarded
- annul_i  in  1  flush of the instruction in EX
- waddr_o  out  REG_ADDR_W  passthrough of waddr_i
- reg_we_o  out  1  write enable, after the overflow kill
- alu_res_o  out  DATA_W  result
- whilo_o  out  1  HI/LO write request
- hi_o, lo_o  out  DATA_W  HI/LO write data
- stall_req_o  out  1  hold PC, IF/ID and ID/EX this cycle

## Operation
- Logic ops: OR, AND, XOR, NOR on reg1 and reg2.
- Shifts: SLL, SRL, SRA of reg2 by reg1[$clog2(DATA_W)-1:0].
- ADD/ADDU, SUB/SUBU: result modulo 2^DATA_W.
  - ADD/SUB signed overflow forces reg_we_o=0; alu_res_o still carries the wrapped sum.
- SLT: signed compare. SLTU: unsigned compare. Result is 1 or 0, zero-extended.
- MFHI/MFLO: alu_res_o = hi_i / lo_i.
- MTHI: whilo_o=1, hi_o=reg1, lo_o=lo_i.
- MTLO: whilo_o=1, hi_o=hi_i, lo_o=reg1.
- MULT/MULTU: 2·DATA_W product. {hi_o,lo_o} = product, whilo_o=1, no stall.
- DIV/DIVU: lo_o = quotient, hi_o = remainder.
  - Signed divide works on magnitudes. Quotient is negated when operand signs differ; remainder takes the dividend's sign.
  - MIN/−1 yields quotient MIN, remainder 0.
  - Divide by zero yields lo_o = all-ones, hi_o = dividend.
- Unknown aluop or alusel: alu_res_o = 0, whilo_o = 0.
- Passthrough: waddr_o = waddr_i. reg_we_o = reg_we_i except on overflow.
- Divider FSM states: FREE, BYZERO, ON, END.
  - FREE + div op + !annul: go to ON (divisor≠0) or BYZERO, and latch operand magnitudes and signs.
  - BYZERO: go to END after 1 cycle.
  - ON: one restoring shift-subtract step per cycle. Go to END after DATA_W steps, tracked by counter cnt.
  - END: results valid, whilo_o=1. Go to FREE.
  - annul_i in any state: go to FREE next cycle. stall_req_o=0 and whilo_o=0 that cycle.
  - Reset in any state: FREE, cnt=0, all internal registers 0.

## Timing
- All non-divide ops have 0-cycle combinational latency. whilo_o and alu_res_o are valid in the cycle the op is presented.
- stall_req_o = 1 during the FREE cycle that accepts a divide, every ON/BYZERO cycle, and 0 in END.
- Divide occupancy is DATA_W+2 cycles (34 at default) and DATA_W-independent 3 cycles for divide-by-zero.
- Inputs must stay stable while stall_req_o=1. The control unit guarantees this.
- The pipeline advances at the end of the END cycle. A divide presented back-to-back in the next cycle is accepted from FREE.
- While rst=1, every output is 0: waddr_o, reg_we_o, alu_res_o, whilo_o, hi_o, lo_o, stall_req_o.

## Configuration
- EX_DIV_EN defined: the divider FSM and ex_div are instantiated.
- EX_DIV_EN undefined:
  - DIV/DIVU take the unknown-op path: whilo_o=0, stall_req_o tied 0.
  - No divider flops exist.

## Structure
- defines.v holds:
  - aluop and alusel codes;
  - `RstEnable`, `ZeroWord`, `AluOpBus`/`AluSelBus`;
  - divider state encodings DIV_FREE/DIV_BYZERO/DIV_ON/DIV_END.
- One sub-module, ex_div (parametrised by DATA_W), contains the FSM, counter and shift-subtract datapath. Its interface is start/signed/annul in and ready/quotient/remainder out.

## Test plan
- ADD 0x7FFFFFFF + 1, reg_we_i=1 -> alu_res_o 0x80000000, reg_we_o=0. ADDU with the same operands -> reg_we_o=1.
- SRA reg2=0x80000000 by reg1=0x24 (shift amount 4) -> 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1. SLT with the same operands -> 0.
- MULT 0xFFFFFFFE × 3 -> hi_o 0xFFFFFFFF, lo_o 0xFFFFFFFA, whilo_o=1, stall_req_o=0.
- DIV −7 / 2 -> 33 cycles of stall_req_o=1, then END with lo_o 0xFFFFFFFD, hi_o 0xFFFFFFFF.
- DIVU 5 / 0 -> 2 stall cycles, then lo_o 0xFFFFFFFF, hi_o 5. annul_i at ON cycle 10 -> next cycle FREE, no whilo_o pulse.
- rst asserted mid-divide -> all outputs 0 that cycle. A new DIVU 100/7 then gives lo_o 14, hi_o 2.
